// File: rtl/pipe_ctl_pkg.sv
// Encodings and instruction-field helpers shared by the Beta pipeline control unit.
package pipe_ctl_pkg;

  localparam logic [1:0] IR_SRC_DATA   = 2'd0;
  localparam logic [1:0] IR_SRC_NOP    = 2'd1;
  localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

  localparam logic [2:0] PC_SEL_INC   = 3'd0;
  localparam logic [2:0] PC_SEL_BR    = 3'd1;
  localparam logic [2:0] PC_SEL_JMP   = 3'd2;
  localparam logic [2:0] PC_SEL_ILLOP = 3'd3;
  localparam logic [2:0] PC_SEL_XADR  = 3'd4;
  localparam logic [2:0] PC_SEL_RESET = 3'd5;

  localparam logic [5:0] OPCODE_LD  = 6'h18;
  localparam logic [5:0] OPCODE_ST  = 6'h19;
  localparam logic [5:0] OPCODE_LDR = 6'h1F;

  // Bit n set when opcode n is implemented: memory/branch ops plus ALU groups 0x20-0x3E (xx7 unused).
  localparam logic [63:0] OPCODE_LEGAL_MASK = 64'h7F7F7F7F_BB000000;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pipe_state_e;

  function automatic logic opcode_legal(input logic [5:0] opcode);
    return OPCODE_LEGAL_MASK[opcode];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the EXEC-stage load and the RF-stage reader.
module hazard_detect
  import pipe_ctl_pkg::*;
(
  input  logic [31:0] ir_rf,
  input  logic [31:0] ir_exec,
  output logic        load_use
);

  logic [5:0] op_rf_s;
  logic [5:0] op_exec_s;
  logic [4:0] rc_rf_s;
  logic [4:0] ra_rf_s;
  logic [4:0] rb_rf_s;
  logic [4:0] rc_exec_s;
  logic       is_load_s;
  logic       reads_s;
  logic       unused_bits_s;

  assign op_rf_s   = ir_rf[31:26];
  assign rc_rf_s   = ir_rf[25:21];
  assign ra_rf_s   = ir_rf[20:16];
  assign rb_rf_s   = ir_rf[15:11];
  assign op_exec_s = ir_exec[31:26];
  assign rc_exec_s = ir_exec[25:21];

  assign is_load_s = (op_exec_s == OPCODE_LD) || (op_exec_s == OPCODE_LDR);

  // rb is only a register source for register-form ALU ops; ST reads its rc as store data.
  assign reads_s = (ra_rf_s == rc_exec_s)
                 || ((op_rf_s[5:4] == 2'b10) && (rb_rf_s == rc_exec_s))
                 || ((op_rf_s == OPCODE_ST) && (rc_rf_s == rc_exec_s));

  assign load_use = is_load_s && (rc_exec_s != 5'd31) && reads_s;

  assign unused_bits_s = ^{ir_rf[10:0], ir_exec[20:0]};

endmodule

// File: rtl/pipe_ctl.sv
// Beta pipeline control: post-reset flush, load-use interlock, exception entry with drain window.
module pipe_ctl
  import pipe_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_rf,
  input  logic [31:0] ir_exec,
  input  logic [31:0] pc_exec,
  input  logic        br_taken_rf,
  input  logic        jmp_rf,
  input  logic        irq,
  output logic [1:0]  ir_src_if,
  output logic [1:0]  ir_src_rf,
  output logic [1:0]  ir_src_exec,
  output logic [2:0]  pc_sel,
  output logic        stall_if,
  output logic        stall_rf
);

  pipe_state_e state_r;
  logic [1:0]  cnt_r;
  logic        load_use_s;
  logic        illop_s;
  logic        int_s;
  logic        except_s;
  logic        unused_bits_s;

  hazard_detect u_hazard_detect (
    .ir_rf    (ir_rf),
    .ir_exec  (ir_exec),
    .load_use (load_use_s)
  );

  assign illop_s  = ~opcode_legal(ir_exec[31:26]);
  assign int_s    = irq & ~pc_exec[31];
  // DRAIN masks exceptions so the faulting instruction's shadow is not re-trapped.
  assign except_s = (state_r == ST_RUN) & (illop_s | int_s);

  assign unused_bits_s = ^pc_exec[30:0];

  // State register and shared flush/drain down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FLUSH;
      cnt_r   <= 2'd2;
    end else begin
      case (state_r)
        ST_FLUSH, ST_DRAIN: begin
          if (cnt_r == 2'd0) begin
            state_r <= ST_RUN;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ST_RUN: begin
          if (except_s) begin
            state_r <= ST_DRAIN;
            cnt_r   <= 2'd1;
          end else begin
            cnt_r <= 2'd0;
          end
        end
        default: begin
          state_r <= ST_FLUSH;
          cnt_r   <= 2'd2;
        end
      endcase
    end
  end

  // Mux selects and stalls, decoded in the same cycle as the inputs
  always_comb begin
    ir_src_if   = IR_SRC_DATA;
    ir_src_rf   = IR_SRC_DATA;
    ir_src_exec = IR_SRC_DATA;
    pc_sel      = PC_SEL_INC;
    stall_if    = 1'b0;
    stall_rf    = 1'b0;
    case (state_r)
      ST_RUN, ST_DRAIN: begin
        if (except_s) begin
          ir_src_if   = IR_SRC_NOP;
          ir_src_rf   = IR_SRC_NOP;
          ir_src_exec = IR_SRC_EXCEPT;
          pc_sel      = illop_s ? PC_SEL_ILLOP : PC_SEL_XADR;
        end else if (load_use_s) begin
          ir_src_rf = IR_SRC_NOP;
          stall_if  = 1'b1;
          stall_rf  = 1'b1;
        end else if (jmp_rf) begin
          ir_src_if = IR_SRC_NOP;
          pc_sel    = PC_SEL_JMP;
        end else if (br_taken_rf) begin
          ir_src_if = IR_SRC_NOP;
          pc_sel    = PC_SEL_BR;
        end else begin
          pc_sel = PC_SEL_INC;
        end
      end
      default: begin
        ir_src_if   = IR_SRC_NOP;
        ir_src_rf   = IR_SRC_NOP;
        ir_src_exec = IR_SRC_NOP;
        pc_sel      = PC_SEL_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_ctl.sv
// Self-checking bench for pipe_ctl: directed scenarios then random traffic against a cycle-count model.
module tb_pipe_ctl;
  import pipe_ctl_pkg::*;

  localparam logic [31:0] NOPI    = 32'h83FFF800;
  localparam logic [31:0] LD_R1   = 32'h60200000;
  localparam logic [31:0] ADD_R1  = 32'h80611000;
  localparam logic [31:0] LD_R31  = 32'h63E00000;
  localparam logic [31:0] ADD_R31 = 32'h807F1000;
  localparam logic [31:0] ILL     = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ir_rf = NOPI;
  logic [31:0] ir_exec = NOPI;
  logic [31:0] pc_exec = 32'h0;
  logic        br_taken_rf = 1'b0;
  logic        jmp_rf = 1'b0;
  logic        irq = 1'b0;
  logic [1:0]  ir_src_if;
  logic [1:0]  ir_src_rf;
  logic [1:0]  ir_src_exec;
  logic [2:0]  pc_sel;
  logic        stall_if;
  logic        stall_rf;

  int n_checks = 0;
  int n_fail   = 0;
  int flush_left = 0;
  int drain_left = 0;

  pipe_ctl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ir_rf       (ir_rf),
    .ir_exec     (ir_exec),
    .pc_exec     (pc_exec),
    .br_taken_rf (br_taken_rf),
    .jmp_rf      (jmp_rf),
    .irq         (irq),
    .ir_src_if   (ir_src_if),
    .ir_src_rf   (ir_src_rf),
    .ir_src_exec (ir_src_exec),
    .pc_sel      (pc_sel),
    .stall_if    (stall_if),
    .stall_rf    (stall_rf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Implemented opcodes: 0x18,0x19,0x1B-0x1D,0x1F and 0x20-0x3F except those ending in 7.
  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F: return 1'b1;
      default: return (op >= 6'h20) && (op % 8 != 7);
    endcase
  endfunction

  function automatic bit is_load_use(input logic [31:0] r, input logic [31:0] e);
    int op_e, rc_e, op_r;
    op_e = e >> 26;
    rc_e = (e >> 21) % 32;
    op_r = r >> 26;
    if (!(op_e == 'h18 || op_e == 'h1F) || rc_e == 31) return 1'b0;
    if ((r >> 16) % 32 == rc_e) return 1'b1;
    if (op_r >= 'h20 && op_r < 'h30 && (r >> 11) % 32 == rc_e) return 1'b1;
    if (op_r == 'h19 && (r >> 21) % 32 == rc_e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outs(input string tag, input logic [5:0] e_src, input logic [2:0] e_pc,
                            input logic [1:0] e_st);
    check({tag, ".ir_src"}, {26'd0, ir_src_if, ir_src_rf, ir_src_exec}, {26'd0, e_src});
    check({tag, ".pc_sel"}, {29'd0, pc_sel}, {29'd0, e_pc});
    check({tag, ".stall"}, {30'd0, stall_if, stall_rf}, {30'd0, e_st});
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_outs(tag, {IR_SRC_NOP, IR_SRC_NOP, IR_SRC_NOP}, PC_SEL_RESET, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    flush_left = 3;
    drain_left = 0;
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic step(input string tag, input logic [31:0] r, input logic [31:0] e,
                      input logic [31:0] p, input logic b, input logic j, input logic q);
    bit         exc;
    logic [5:0] e_src;
    logic [2:0] e_pc;
    logic [1:0] e_st;
    ir_rf = r; ir_exec = e; pc_exec = p; br_taken_rf = b; jmp_rf = j; irq = q;
    exc   = 1'b0;
    e_src = {IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA};
    e_pc  = PC_SEL_INC;
    e_st  = 2'b00;
    if (flush_left > 0) begin
      e_src = {IR_SRC_NOP, IR_SRC_NOP, IR_SRC_NOP};
      e_pc  = PC_SEL_RESET;
    end else begin
      exc = (drain_left == 0) && (!is_legal(e[31:26]) || (q && !p[31]));
      if (exc) begin
        e_src = {IR_SRC_NOP, IR_SRC_NOP, IR_SRC_EXCEPT};
        e_pc  = is_legal(e[31:26]) ? PC_SEL_XADR : PC_SEL_ILLOP;
      end else if (is_load_use(r, e)) begin
        e_src = {IR_SRC_DATA, IR_SRC_NOP, IR_SRC_DATA};
        e_st  = 2'b11;
      end else if (j || b) begin
        e_src = {IR_SRC_NOP, IR_SRC_DATA, IR_SRC_DATA};
        e_pc  = j ? PC_SEL_JMP : PC_SEL_BR;
      end
    end
    @(negedge clk);
    check_outs(tag, e_src, e_pc, e_st);
    @(posedge clk);
    if (flush_left > 0) flush_left--;
    else if (drain_left > 0) drain_left--;
    else if (exc) drain_left = 2;
    #1;
  endtask

  function automatic logic [4:0] rand_reg();
    case ($urandom_range(0, 2))
      0: return 5'd1;
      1: return 5'd2;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [5:0] op;
    case ($urandom_range(0, 7))
      0: op = 6'h18;
      1: op = 6'h1F;
      2: op = 6'h19;
      3: op = 6'h20;
      4: op = 6'h2A;
      5: op = 6'h30;
      6: op = 6'h00;
      default: op = 6'h27;
    endcase
    return {op, rand_reg(), rand_reg(), rand_reg(), 11'($urandom)};
  endfunction

  initial begin
    #1;
    do_reset("reset");
    for (int i = 0; i < 3; i++) step("flush", NOPI, NOPI, 32'h0, 1'b0, 1'b0, 1'b0);
    step("run", NOPI, NOPI, 32'h0, 1'b0, 1'b0, 1'b0);

    step("lduse", ADD_R1, LD_R1, 32'h0, 1'b0, 1'b0, 1'b0);
    step("lduse_clear", ADD_R1, NOPI, 32'h0, 1'b0, 1'b0, 1'b0);
    step("ld_r31", ADD_R31, LD_R31, 32'h0, 1'b0, 1'b0, 1'b0);
    step("st_rc", 32'h64200000, 32'h7C200000, 32'h0, 1'b0, 1'b0, 1'b0);
    step("lit_rb", 32'hC0600800, LD_R1, 32'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) step("illop", NOPI, ILL, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step("drain", NOPI, NOPI, 32'h0, 1'b0, 1'b0, 1'b0);

    step("irq_super", NOPI, NOPI, 32'h80000010, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("irq_user", NOPI, NOPI, 32'h00000010, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step("drain", NOPI, NOPI, 32'h0, 1'b0, 1'b0, 1'b0);
    step("irq_illop", NOPI, ILL, 32'h00000010, 1'b0, 1'b0, 1'b1);
    step("drain_br", NOPI, NOPI, 32'h0, 1'b1, 1'b0, 1'b0);
    step("drain_lduse", ADD_R1, LD_R1, 32'h0, 1'b0, 1'b0, 1'b0);

    step("lduse_br", ADD_R1, LD_R1, 32'h0, 1'b1, 1'b0, 1'b0);
    step("br", ADD_R1, NOPI, 32'h0, 1'b1, 1'b0, 1'b0);
    step("jmp", ADD_R1, NOPI, 32'h0, 1'b1, 1'b1, 1'b0);

    step("enter_drain", NOPI, ILL, 32'h0, 1'b0, 1'b0, 1'b0);
    do_reset("reset_drain");
    step("flush_again", NOPI, ILL, 32'h0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rand_reset");
      step("rand", rand_ir(), rand_ir(), {1'($urandom), 31'h10},
           $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
